// File: rtl/tape_pkg.sv
// Shared types and constants for the tape-image SDRAM arbiter.
package tape_pkg;
    localparam int         AW_DEFAULT   = 25;
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;
endpackage

// File: rtl/tape_sdram_arb_if.sv
// Downloader, cassette-player and SDRAM-controller signals seen by the tape arbiter.
interface tape_sdram_arb_if #(
    parameter int AW = tape_pkg::AW_DEFAULT
);
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait;
    logic          tp_rd;
    logic [AW-1:0] tp_addr;
    logic [7:0]    tp_data;
    logic          tp_valid;
    logic          tp_busy;
    logic [AW-1:0] tape_len;
    logic          tape_len_valid;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din;
    logic          sd_we;
    logic          sd_rd;
    logic [7:0]    sd_dout;
    logic          sd_ready;
    logic          err;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, tp_rd, tp_addr, sd_dout, sd_ready,
        output dl_wait, tp_data, tp_valid, tp_busy, tape_len, tape_len_valid,
        output sd_addr, sd_din, sd_we, sd_rd, err
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, tp_rd, tp_addr, sd_dout, sd_ready,
        input  dl_wait, tp_data, tp_valid, tp_busy, tape_len, tape_len_valid,
        input  sd_addr, sd_din, sd_we, sd_rd, err
    );
endinterface

// File: rtl/tape_sdram_arb.sv
// Shares one 8-bit SDRAM port between tape download (writes, priority) and playback (reads),
// one command outstanding at a time; also records the length of the last downloaded image.
module tape_sdram_arb
    import tape_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int MIN_BUSY = 2,
    parameter int TIMEOUT  = 255
) (
    input logic             clk_sys,
    input logic             reset,
    tape_sdram_arb_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic          is_wr_q;
    logic [CW-1:0] cnt_q;
    logic          wr_pend_q, rd_pend_q;
    logic [AW-1:0] wr_addr_q, rd_addr_q;
    logic [7:0]    wr_data_q;
    logic [AW-1:0] sd_addr_q;
    logic [7:0]    sd_din_q, tp_data_q;
    logic          sd_we_q, sd_rd_q, tp_valid_q, dl_wait_q, err_q;
    logic          dl_active_q, have_wr_q, fin_pend_q, tape_len_valid_q;
    logic [AW-1:0] max_addr_q, max_addr_d, tape_len_q;

    logic dl_rise, dl_fall, rd_txn, wr_accept, rd_accept, wait_ok, wait_to;

    assign dl_rise   = bus.dl_active & ~dl_active_q;
    assign dl_fall   = ~bus.dl_active & dl_active_q;
    assign rd_txn    = (state_q != IDLE) & ~is_wr_q;
    // dl_wait_q covers both a pending write and one in ISSUE/WAIT, so it doubles as the busy guard
    assign wr_accept = bus.dl_wr & ~dl_wait_q;
    assign rd_accept = bus.tp_rd & ~bus.dl_active & ~rd_pend_q & ~rd_txn;
    assign wait_ok   = (cnt_q >= CW'(MIN_BUSY)) & bus.sd_ready;
    assign wait_to   = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        max_addr_d = bus.dl_addr;
        if (have_wr_q && !dl_rise && (max_addr_q > bus.dl_addr)) max_addr_d = max_addr_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            is_wr_q          <= 1'b0;
            cnt_q            <= '0;
            wr_pend_q        <= 1'b0;
            rd_pend_q        <= 1'b0;
            wr_addr_q        <= '0;
            rd_addr_q        <= '0;
            wr_data_q        <= '0;
            sd_addr_q        <= '0;
            sd_din_q         <= '0;
            tp_data_q        <= '0;
            sd_we_q          <= 1'b0;
            sd_rd_q          <= 1'b0;
            tp_valid_q       <= 1'b0;
            dl_wait_q        <= 1'b0;
            err_q            <= 1'b0;
            dl_active_q      <= 1'b0;
            have_wr_q        <= 1'b0;
            fin_pend_q       <= 1'b0;
            tape_len_valid_q <= 1'b0;
            max_addr_q       <= '0;
            tape_len_q       <= '0;
        end else begin
            dl_active_q <= bus.dl_active;
            tp_valid_q  <= 1'b0;

            if (dl_rise) begin
                rd_pend_q        <= 1'b0;
                tape_len_valid_q <= 1'b0;
                fin_pend_q       <= 1'b0;
                max_addr_q       <= '0;
                have_wr_q        <= 1'b0;
            end else if (rd_accept) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= bus.tp_addr;
            end

            if (wr_accept) begin
                wr_pend_q  <= 1'b1;
                dl_wait_q  <= 1'b1;
                wr_addr_q  <= bus.dl_addr;
                wr_data_q  <= bus.dl_data;
                max_addr_q <= max_addr_d;
                have_wr_q  <= 1'b1;
            end

            // Length is published only after the last write has left the SDRAM port
            if (dl_fall) begin
                fin_pend_q <= 1'b1;
            end else if (fin_pend_q && !dl_wait_q && !wr_accept && !dl_rise) begin
                fin_pend_q       <= 1'b0;
                tape_len_q       <= have_wr_q ? (max_addr_q + AW'(1)) : '0;
                tape_len_valid_q <= have_wr_q;
            end

            case (state_q)
                IDLE: begin
                    if (bus.sd_ready && wr_pend_q) begin
                        state_q   <= ISSUE;
                        is_wr_q   <= 1'b1;
                        sd_we_q   <= 1'b1;
                        sd_addr_q <= wr_addr_q;
                        sd_din_q  <= wr_data_q;
                    end else if (bus.sd_ready && rd_pend_q && !dl_rise) begin
                        state_q   <= ISSUE;
                        is_wr_q   <= 1'b0;
                        sd_rd_q   <= 1'b1;
                        sd_addr_q <= rd_addr_q;
                    end
                end
                ISSUE: begin
                    sd_we_q <= 1'b0;
                    sd_rd_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                    if (is_wr_q) wr_pend_q <= 1'b0;
                    else         rd_pend_q <= 1'b0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (wait_ok || wait_to) begin
                        state_q    <= DONE;
                        tp_valid_q <= ~is_wr_q;
                        if (is_wr_q) dl_wait_q <= 1'b0;
                        else         tp_data_q <= wait_ok ? bus.sd_dout : TIMEOUT_FILL;
                        if (!wait_ok) err_q <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dl_wait        = dl_wait_q;
    assign bus.tp_data        = tp_data_q;
    assign bus.tp_valid       = tp_valid_q;
    assign bus.tp_busy        = bus.dl_active | rd_pend_q | rd_txn;
    assign bus.tape_len       = tape_len_q;
    assign bus.tape_len_valid = tape_len_valid_q;
    assign bus.sd_addr        = sd_addr_q;
    assign bus.sd_din         = sd_din_q;
    assign bus.sd_we          = sd_we_q;
    assign bus.sd_rd          = sd_rd_q;
    assign bus.err            = err_q;
endmodule
